bus_addr_router: RTL and testbench

Single-outstanding request router that sits directly downstream of `address_selector` and consumes its `selector`/`nmatch` outputs. It accepts register-bus requests from one upstream master, decodes the target with an internal `address_selector` instance, forwards each request to exactly one of `COUNT` slave ports, and returns one response per request. Unmatched addresses get an error response and are never forwarded. An optional watchdog aborts slaves that stall.

---
 rtl/bus_addr_router_if.sv | 38 +++
 rtl/bus_addr_router.sv | 213 +++++++++++++++++++++
 tb/tb_bus_addr_router.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_addr_router_if.sv
// Register-bus bundle for bus_addr_router: upstream request/response plus the
// per-slave request/read-data lanes. The router takes the slave view.
interface bus_addr_router_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int COUNT      = 2
);
    logic                        s_req_valid;
    logic                        s_req_ready;
    logic                        s_req_wr;
    logic [ADDR_WIDTH-1:0]       s_req_addr;
    logic [DATA_WIDTH-1:0]       s_req_wdata;
    logic                        s_rsp_valid;
    logic                        s_rsp_err;
    logic [DATA_WIDTH-1:0]       s_rsp_rdata;
    logic [COUNT-1:0]            m_req_valid;
    logic [COUNT-1:0]            m_req_ready;
    logic                        m_req_wr;
    logic [ADDR_WIDTH-1:0]       m_req_addr;
    logic [DATA_WIDTH-1:0]       m_req_wdata;
    logic [COUNT-1:0]            m_rsp_valid;
    logic [COUNT*DATA_WIDTH-1:0] m_rsp_rdata;

    // The router sits on this side: it answers upstream and drives the slaves
    modport slave (
        input  s_req_valid, s_req_wr, s_req_addr, s_req_wdata,
        input  m_req_ready, m_rsp_valid, m_rsp_rdata,
        output s_req_ready, s_rsp_valid, s_rsp_err, s_rsp_rdata,
        output m_req_valid, m_req_wr, m_req_addr, m_req_wdata
    );

    modport master (
        output s_req_valid, s_req_wr, s_req_addr, s_req_wdata,
        output m_req_ready, m_rsp_valid, m_rsp_rdata,
        input  s_req_ready, s_rsp_valid, s_rsp_err, s_rsp_rdata,
        input  m_req_valid, m_req_wr, m_req_addr, m_req_wdata
    );
endinterface

// File: rtl/bus_addr_router.sv
// Single-outstanding register-bus router with a built-in mask/compare decoder.
// Optional slave watchdog is enabled by defining BUS_ADDR_ROUTER_TIMEOUT_EN.
module address_selector #(
    parameter int                            ADDR_WIDTH = 32,
    parameter int                            ADDR_ALIGN = 32,
    parameter int                            COUNT      = 2,
    parameter int                            SEL_WIDTH  = 1,
    parameter logic [COUNT*ADDR_ALIGN-1:0]   ADDR_MASK  = '0,
    parameter logic [COUNT*ADDR_ALIGN-1:0]   ADDR_COMP  = '0
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [SEL_WIDTH-1:0]  selector,
    output logic                  nmatch
);
    logic [ADDR_ALIGN-1:0] addr_fit;

    generate
        if (ADDR_ALIGN > ADDR_WIDTH) begin : g_widen
            assign addr_fit = {{(ADDR_ALIGN-ADDR_WIDTH){1'b0}}, addr};
        end else begin : g_narrow
            assign addr_fit = addr[ADDR_ALIGN-1:0];
        end
    endgenerate

    // Scan from the top so the lowest-index match is the one left standing
    always_comb begin
        selector = '0;
        nmatch   = 1'b1;
        for (int i = COUNT - 1; i >= 0; i--) begin
            if ((addr_fit & ADDR_MASK[i*ADDR_ALIGN +: ADDR_ALIGN]) ==
                ADDR_COMP[i*ADDR_ALIGN +: ADDR_ALIGN]) begin
                selector = i[SEL_WIDTH-1:0];
                nmatch   = 1'b0;
            end
        end
    end
endmodule

module bus_addr_router #(
    parameter int                            ADDR_WIDTH   = 32,
    parameter int                            DATA_WIDTH   = 32,
    parameter int                            ADDR_ALIGN   = 32,
    parameter int                            COUNT        = 2,
    parameter logic [COUNT*ADDR_ALIGN-1:0]   ADDR_MASK    = '0,
    parameter logic [COUNT*ADDR_ALIGN-1:0]   ADDR_COMP    = '0,
    parameter int                            TIMEOUT_BITS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    bus_addr_router_if.slave  bus
);
    localparam int SEL_WIDTH = (COUNT > 1) ? $clog2(COUNT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        FWD,
        RWAIT,
        RESP
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [SEL_WIDTH-1:0]   dec_sel;
    logic                   dec_nmatch;
    logic [SEL_WIDTH-1:0]   sel;
    logic                   wr_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic                   rsp_err_q;
    logic                   rsp_err_next;
    logic [DATA_WIDTH-1:0]  rsp_rdata_q;
    logic [DATA_WIDTH-1:0]  rsp_rdata_next;
    logic                   accept;
    logic                   expire;
    logic                   sel_ready;
    logic                   sel_rsp;
    logic [DATA_WIDTH-1:0]  sel_rdata;
    logic [COUNT-1:0]       sel_onehot;

    address_selector #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ADDR_ALIGN (ADDR_ALIGN),
        .COUNT      (COUNT),
        .SEL_WIDTH  (SEL_WIDTH),
        .ADDR_MASK  (ADDR_MASK),
        .ADDR_COMP  (ADDR_COMP)
    ) u_decoder (
        .addr     (bus.s_req_addr),
        .selector (dec_sel),
        .nmatch   (dec_nmatch)
    );

    assign accept = bus.s_req_valid && (state == IDLE);

    // Only the selected slave's lanes are ever looked at
    always_comb begin
        sel_ready  = 1'b0;
        sel_rsp    = 1'b0;
        sel_rdata  = '0;
        sel_onehot = '0;
        for (int i = 0; i < COUNT; i++) begin
            if (sel == i[SEL_WIDTH-1:0]) begin
                sel_ready     = bus.m_req_ready[i];
                sel_rsp       = bus.m_rsp_valid[i];
                sel_rdata     = bus.m_rsp_rdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_onehot[i] = 1'b1;
            end
        end
    end

`ifdef BUS_ADDR_ROUTER_TIMEOUT_EN
    logic [TIMEOUT_BITS-1:0] wd_count;
    logic [TIMEOUT_BITS-1:0] wd_inc;

    assign wd_inc = wd_count + TIMEOUT_BITS'(1);
    assign expire = ((state == FWD) || (state == RWAIT)) && (&wd_inc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_count <= '0;
        end else if (accept) begin
            wd_count <= '0;
        end else if ((state == FWD) || (state == RWAIT)) begin
            wd_count <= wd_inc;
        end
    end
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sel         <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state       <= state_next;
            rsp_err_q   <= rsp_err_next;
            rsp_rdata_q <= rsp_rdata_next;
            if (accept) begin
                sel     <= dec_sel;
                wr_q    <= bus.s_req_wr;
                addr_q  <= bus.s_req_addr;
                wdata_q <= bus.s_req_wdata;
            end
        end
    end

    // Slave handshakes and read data win over a watchdog expiry in the same cycle
    always_comb begin
        state_next     = state;
        rsp_err_next   = rsp_err_q;
        rsp_rdata_next = rsp_rdata_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (dec_nmatch) begin
                        state_next     = RESP;
                        rsp_err_next   = 1'b1;
                        rsp_rdata_next = '1;
                    end else begin
                        state_next = FWD;
                    end
                end
            end
            FWD: begin
                if (sel_ready) begin
                    if (wr_q) begin
                        state_next     = RESP;
                        rsp_err_next   = 1'b0;
                        rsp_rdata_next = '0;
                    end else begin
                        state_next = RWAIT;
                    end
                end else if (expire) begin
                    state_next     = RESP;
                    rsp_err_next   = 1'b1;
                    rsp_rdata_next = '1;
                end
            end
            RWAIT: begin
                if (sel_rsp) begin
                    state_next     = RESP;
                    rsp_err_next   = 1'b0;
                    rsp_rdata_next = sel_rdata;
                end else if (expire) begin
                    state_next     = RESP;
                    rsp_err_next   = 1'b1;
                    rsp_rdata_next = '1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.s_req_ready = (state == IDLE);
    assign bus.s_rsp_valid = (state == RESP);
    assign bus.s_rsp_err   = rsp_err_q;
    assign bus.s_rsp_rdata = rsp_rdata_q;
    assign bus.m_req_valid = (state == FWD) ? sel_onehot : '0;
    assign bus.m_req_wr    = wr_q;
    assign bus.m_req_addr  = addr_q;
    assign bus.m_req_wdata = wdata_q;
endmodule

// File: tb/tb_bus_addr_router.sv
// Scoreboard bench for bus_addr_router: slot 0 covers 0x1000-0x1FFF, slot 1
// covers 0x0000-0x1FFF, so 0x1xxx exercises lowest-index priority.
module tb_bus_addr_router;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int CNT = 2;

    typedef struct {
        logic          err;
        logic [DW-1:0] rdata;
        int            cycle;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cycle = 0;
    int   checks = 0;
    int   failures = 0;
    int   acc;
    rsp_t exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    bus_addr_router_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .COUNT(CNT)) bus ();

    bus_addr_router #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .ADDR_ALIGN   (32),
        .COUNT        (CNT),
        .ADDR_MASK    (64'hFFFF_E000_FFFF_F000),
        .ADDR_COMP    (64'h0000_0000_0000_1000),
        .TIMEOUT_BITS (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Presents one request and returns the cycle in which it was accepted
    task automatic applyStimulus(input logic wr, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata, output int acc_cycle);
        acc_cycle = -1;
        bus.s_req_valid = 1'b1;
        bus.s_req_wr    = wr;
        bus.s_req_addr  = addr;
        bus.s_req_wdata = wdata;
        for (int k = 0; k < 50; k++) begin
            if (bus.s_req_ready) begin
                acc_cycle = cycle;
                break;
            end
            stepCycle();
        end
        if (acc_cycle < 0) checkOutput("accept_timeout", 64'(0), 64'(1));
        stepCycle();
        bus.s_req_valid = 1'b0;
        bus.s_req_addr  = 32'h0000_2000;
        bus.s_req_wdata = 32'hBAD0_BAD0;
    endtask

    task automatic pushExpected(input logic err, input logic [DW-1:0] rdata, input int at);
        rsp_t e;
        e.err   = err;
        e.rdata = rdata;
        e.cycle = at;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        rsp_t e;
        if (bus.s_rsp_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_rsp", 64'(1), 64'(0));
            end else begin
                e = exp_q.pop_front();
                checkOutput("rsp_err", 64'(bus.s_rsp_err), 64'(e.err));
                checkOutput("rsp_rdata", 64'(bus.s_rsp_rdata), 64'(e.rdata));
                checkOutput("rsp_cycle", 64'(cycle), 64'(e.cycle));
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        bus.s_req_valid = 1'b1;
        bus.s_req_wr    = 1'b1;
        bus.s_req_addr  = 32'h0000_0010;
        bus.s_req_wdata = 32'h1111_1111;
        bus.m_req_ready = '0;
        bus.m_rsp_valid = '0;
        bus.m_rsp_rdata = '0;

        // Reset values, with a request held during reset that must be ignored
        repeat (3) stepCycle();
        checkOutput("rst_s_req_ready", 64'(bus.s_req_ready), 64'(1));
        checkOutput("rst_m_req_valid", 64'(bus.m_req_valid), 64'(0));
        checkOutput("rst_s_rsp_valid", 64'(bus.s_rsp_valid), 64'(0));
        checkOutput("rst_s_rsp_err", 64'(bus.s_rsp_err), 64'(0));
        checkOutput("rst_s_rsp_rdata", 64'(bus.s_rsp_rdata), 64'(0));
        checkOutput("rst_m_req_wr", 64'(bus.m_req_wr), 64'(0));
        checkOutput("rst_m_req_addr", 64'(bus.m_req_addr), 64'(0));
        checkOutput("rst_m_req_wdata", 64'(bus.m_req_wdata), 64'(0));
        bus.s_req_valid = 1'b0;
        rst_n = 1'b1;
        stepCycle();
        checkOutput("post_rst_ready", 64'(bus.s_req_ready), 64'(1));
        checkOutput("post_rst_m_valid", 64'(bus.m_req_valid), 64'(0));

        // Posted write to slave 1 with ready already high
        bus.m_req_ready = 2'b11;
        applyStimulus(1'b1, 32'h0000_0010, 32'h1234_5678, acc);
        pushExpected(1'b0, 32'h0, acc + 2);
        checkOutput("wr_m_valid", 64'(bus.m_req_valid), 64'(2'b10));
        checkOutput("wr_m_wdata", 64'(bus.m_req_wdata), 64'(32'h1234_5678));
        checkOutput("wr_m_addr", 64'(bus.m_req_addr), 64'(32'h0000_0010));
        checkOutput("wr_m_wr", 64'(bus.m_req_wr), 64'(1));
        checkOutput("wr_busy_ready", 64'(bus.s_req_ready), 64'(0));
        stepCycle();
        checkOutput("wr_resp_m_valid", 64'(bus.m_req_valid), 64'(0));
        stepCycle();
        checkOutput("wr_idle_ready", 64'(bus.s_req_ready), 64'(1));
        checkOutput("wr_hold_wdata", 64'(bus.m_req_wdata), 64'(32'h1234_5678));

        // Read at an address both slots match: slot 0 wins; stray strobes ignored
        applyStimulus(1'b0, 32'h0000_1004, 32'h0, acc);
        pushExpected(1'b0, 32'hCAFE_F00D, acc + 4);
        checkOutput("prio_m_valid", 64'(bus.m_req_valid), 64'(2'b01));
        bus.m_rsp_valid = 2'b01;
        bus.m_rsp_rdata = {32'h0, 32'hDEAD_BEEF};
        stepCycle();
        checkOutput("rwait_m_valid", 64'(bus.m_req_valid), 64'(0));
        bus.m_rsp_valid = 2'b10;
        bus.m_rsp_rdata = {32'h1111_1111, 32'h0};
        stepCycle();
        bus.m_rsp_valid = 2'b01;
        bus.m_rsp_rdata = {32'h2222_2222, 32'hCAFE_F00D};
        stepCycle();
        bus.m_rsp_valid = '0;
        bus.m_rsp_rdata = '0;
        stepCycle();

        // Read to slave 1 with data returned one cycle after the handshake
        applyStimulus(1'b0, 32'h0000_0020, 32'h0, acc);
        pushExpected(1'b0, 32'h0BAD_C0DE, acc + 3);
        checkOutput("rd1_m_valid", 64'(bus.m_req_valid), 64'(2'b10));
        stepCycle();
        bus.m_rsp_valid = 2'b10;
        bus.m_rsp_rdata = {32'h0BAD_C0DE, 32'h5555_5555};
        stepCycle();
        bus.m_rsp_valid = '0;
        bus.m_rsp_rdata = '0;
        stepCycle();

        // Unmatched address is answered with an error and never forwarded
        applyStimulus(1'b0, 32'h0000_2000, 32'h0, acc);
        pushExpected(1'b1, 32'hFFFF_FFFF, acc + 1);
        checkOutput("nomatch_m_valid", 64'(bus.m_req_valid), 64'(0));
        stepCycle();
        checkOutput("nomatch_m_valid2", 64'(bus.m_req_valid), 64'(0));
        stepCycle();

        // Slave stalls ready for five cycles
        bus.m_req_ready = 2'b00;
        applyStimulus(1'b1, 32'h0000_0044, 32'h0000_A5A5, acc);
        pushExpected(1'b0, 32'h0, acc + 7);
        for (int k = 0; k < 5; k++) begin
            checkOutput("stall_m_valid", 64'(bus.m_req_valid), 64'(2'b10));
            checkOutput("stall_ready", 64'(bus.s_req_ready), 64'(0));
            checkOutput("stall_m_addr", 64'(bus.m_req_addr), 64'(32'h0000_0044));
            stepCycle();
        end
        bus.m_req_ready = 2'b11;
        checkOutput("stall_last_valid", 64'(bus.m_req_valid), 64'(2'b10));
        stepCycle();
        checkOutput("stall_done_valid", 64'(bus.m_req_valid), 64'(0));
        repeat (2) stepCycle();

        // Read to a slave that never answers
        applyStimulus(1'b0, 32'h0000_1000, 32'h0, acc);
`ifdef BUS_ADDR_ROUTER_TIMEOUT_EN
        pushExpected(1'b1, 32'hFFFF_FFFF, acc + 16);
        repeat (20) stepCycle();
        checkOutput("timeout_ready", 64'(bus.s_req_ready), 64'(1));
`else
        repeat (1000) stepCycle();
        checkOutput("hang_ready", 64'(bus.s_req_ready), 64'(0));
        rst_n = 1'b0;
        stepCycle();
        rst_n = 1'b1;
        stepCycle();
`endif

        // Reset asserted while waiting for read data
        applyStimulus(1'b0, 32'h0000_0080, 32'h0, acc);
        checkOutput("rr_fwd_valid", 64'(bus.m_req_valid), 64'(2'b10));
        stepCycle();
        checkOutput("rr_rwait_ready", 64'(bus.s_req_ready), 64'(0));
        rst_n = 1'b0;
        bus.s_req_valid = 1'b1;
        bus.s_req_wr    = 1'b1;
        bus.s_req_addr  = 32'h0000_0010;
        #1;
        checkOutput("rr_m_valid", 64'(bus.m_req_valid), 64'(0));
        checkOutput("rr_rsp_valid", 64'(bus.s_rsp_valid), 64'(0));
        checkOutput("rr_ready", 64'(bus.s_req_ready), 64'(1));
        checkOutput("rr_m_addr", 64'(bus.m_req_addr), 64'(0));
        repeat (2) stepCycle();
        bus.s_req_valid = 1'b0;
        rst_n = 1'b1;
        stepCycle();
        checkOutput("rr_release_ready", 64'(bus.s_req_ready), 64'(1));
        applyStimulus(1'b1, 32'h0000_0010, 32'h55AA_55AA, acc);
        pushExpected(1'b0, 32'h0, acc + 2);
        checkOutput("rr_next_m_valid", 64'(bus.m_req_valid), 64'(2'b10));
        checkOutput("rr_next_wdata", 64'(bus.m_req_wdata), 64'(32'h55AA_55AA));

        repeat (5) stepCycle();
        checkOutput("pending_rsp", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
